// File: rtl/player_motion.sv
// Per-frame player ship controller: moves the ship on each vsync tick and raises a held fire request.
// PlayerX/FireReq update one Clk edge after the tick; vsync rising edge to tick is 3 Clk edges.
module player_motion #(
  parameter int X_START         = 320,
  parameter int Y_POS           = 440,
  parameter int X_MIN           = 12,
  parameter int X_MAX           = 627,
  parameter int STEP            = 2,
  parameter int SIZE            = 8,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic [4:0] Size,
  output logic       FireReq,
  input  logic       FireAck,
  output logic [9:0] ShotX,
  output logic [9:0] ShotY
);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_FIRE  = 8'h2C;

  localparam logic [9:0] XSTART    = 10'(X_START);
  localparam logic [9:0] XMIN      = 10'(X_MIN);
  localparam logic [9:0] XMAX      = 10'(X_MAX);
  localparam logic [9:0] XSTEP     = 10'(STEP);
  localparam logic [9:0] LEFT_LIM  = 10'(X_MIN + STEP);
  localparam logic [9:0] RIGHT_LIM = 10'(X_MAX - STEP);
  localparam logic [7:0] CD_LOAD   = 8'(COOLDOWN_FRAMES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  logic       vsync_meta, vsync_sync, vsync_prev;
  logic       tick;
  logic [1:0] state;
  logic [7:0] cnt;
  logic       space_prev;
  logic       is_fire;

  assign is_fire = (keycode == KEY_FIRE);

  assign PlayerY = 10'(Y_POS);
  assign Size    = 5'(SIZE);
  assign ShotY   = 10'(Y_POS - SIZE);

  // frame_clk is asynchronous: two flops for metastability, a third for the rising-edge compare
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vsync_meta <= 1'b0;
      vsync_sync <= 1'b0;
      vsync_prev <= 1'b0;
      tick       <= 1'b0;
    end else begin
      vsync_meta <= frame_clk;
      vsync_sync <= vsync_meta;
      vsync_prev <= vsync_sync;
      tick       <= vsync_sync & ~vsync_prev;
    end
  end

  // Compare against the limit before stepping so the unsigned position never wraps
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      PlayerX <= XSTART;
    end else if (tick) begin
      if (keycode == KEY_LEFT) begin
        PlayerX <= (PlayerX < LEFT_LIM) ? XMIN : PlayerX - XSTEP;
      end else if (keycode == KEY_RIGHT) begin
        PlayerX <= (PlayerX > RIGHT_LIM) ? XMAX : PlayerX + XSTEP;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      space_prev <= 1'b1;
      FireReq    <= 1'b0;
      ShotX      <= XSTART;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick && is_fire && !space_prev) begin
            state   <= S_REQ;
            FireReq <= 1'b1;
            ShotX   <= PlayerX;
          end
        end
        S_REQ: begin
          if (FireAck) begin
            state   <= S_COOL;
            FireReq <= 1'b0;
            cnt     <= CD_LOAD;
          end
        end
        S_COOL: begin
          if (tick) begin
            if (cnt == 8'd1) begin
              state <= S_IDLE;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // Tracks the key in every state, so a press swallowed during REQ/COOLDOWN needs a re-press
      if (tick) space_prev <= is_fire;
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Randomized-phase bench for player_motion with a frame-level reference model.
`timescale 1ns/1ps
module tb_player_motion;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] PlayerX, PlayerY, ShotX, ShotY;
  logic [4:0] Size;
  logic       FireReq, FireAck;
  logic       ack_man = 1'b0, auto_ack = 1'b0, rand_ack = 1'b0, chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int req_rises = 0;
  logic req_last = 1'b0;

  always #5 Clk = ~Clk;

  assign FireAck = auto_ack ? FireReq : ack_man;

  player_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .Size(Size), .FireReq(FireReq),
    .FireAck(FireAck), .ShotX(ShotX), .ShotY(ShotY)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level behaviour; the tick lands 3 edges after vsync is first sampled high
  int mx, mshotx, mcool;
  bit mreq, mprev, mtick, fire_key;
  bit samp [3];

  always @(posedge Clk) begin
    if (!Reset_n) begin
      mx = 320; mshotx = 320; mcool = 0; mreq = 0; mprev = 1; mtick = 0;
      samp[0] = 0; samp[1] = 0; samp[2] = 0;
    end else begin
      fire_key = (keycode == 8'h2C);
      if (mreq) begin
        if (FireAck) begin mreq = 0; mcool = 8; end
      end else if (mcool > 0) begin
        if (mtick) mcool--;
      end else if (mtick && fire_key && !mprev) begin
        mreq = 1; mshotx = mx;
      end
      if (mtick) begin
        if (keycode == 8'h04)      mx = (mx - 2 < 12) ? 12 : mx - 2;
        else if (keycode == 8'h07) mx = (mx + 2 > 627) ? 627 : mx + 2;
        mprev = fire_key;
      end
      mtick = samp[1] && !samp[2];
      samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = frame_clk;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("PlayerX", int'(PlayerX), mx);
      check("FireReq", int'(FireReq), int'(mreq));
      check("ShotX",   int'(ShotX),   mshotx);
      check("PlayerY", int'(PlayerY), 440);
      check("Size",    int'(Size),    8);
      check("ShotY",   int'(ShotY),   432);
      if (FireReq && !req_last) req_rises++;
      req_last = FireReq;
    end
  end

  task automatic cyc();
    @(negedge Clk);
    if (rand_ack) ack_man = ($urandom_range(0, 2) == 0);
  endtask

  // One vsync pulse with random phase and width; key held until well after the tick is consumed
  task automatic do_tick(input logic [7:0] k);
    int hi, lo;
    @(negedge Clk);
    keycode = k;
    #($urandom_range(0, 3)) frame_clk = 1'b1;
    hi = $urandom_range(1, 5);
    lo = $urandom_range(4, 7);
    repeat (hi) cyc();
    #($urandom_range(0, 3)) frame_clk = 1'b0;
    repeat (lo) cyc();
  endtask

  // Raises vsync exactly on a negedge and waits (bounded) for FireReq; returns cycles waited
  task automatic press_and_wait(output int lat);
    keycode = 8'h2C;
    cyc();
    frame_clk = 1'b1;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (FireReq) begin lat = i; break; end
    end
    frame_clk = 1'b0;
  endtask

  int px0, lat, r0;
  logic [7:0] keys [5];

  initial begin
    keys[0] = 8'h04; keys[1] = 8'h07; keys[2] = 8'h2C; keys[3] = 8'h00; keys[4] = 8'h00;
    @(negedge Clk);
    chk_en = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    check("rst_PlayerX", int'(PlayerX), 320);
    check("rst_FireReq", int'(FireReq), 0);
    check("rst_ShotX",   int'(ShotX),   320);

    // Right steps
    repeat (5) do_tick(8'h07);
    check("t1_PlayerX", int'(PlayerX), 330);
    check("t1_model_x", mx, 330);
    check("t1_FireReq", int'(FireReq), 0);
    check("t1_PlayerY", int'(PlayerY), 440);
    check("t1_Size",    int'(Size), 8);

    // Left clamp from 330 (5 extra ticks absorbs the offset), then right clamp
    repeat (154 + 5) do_tick(8'h04);
    check("t2_left_clamp", int'(PlayerX), 12);
    repeat (5) do_tick(8'h04);
    check("t2_left_hold", int'(PlayerX), 12);
    repeat (307) do_tick(8'h07);
    check("t2_x626", int'(PlayerX), 626);
    do_tick(8'h07);
    check("t2_right_clamp", int'(PlayerX), 627);
    repeat (3) do_tick(8'h07);
    check("t2_right_hold", int'(PlayerX), 627);

    // Single shot with delayed ack
    px0 = int'(PlayerX);
    press_and_wait(lat);
    check("t3_fire_latency", lat, 3);
    keycode = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t3_req_held", int'(FireReq), 1);
    end
    ack_man = 1'b1;
    cyc();
    ack_man = 1'b0;
    check("t3_req_drop", int'(FireReq), 0);
    check("t3_ShotX", int'(ShotX), px0);
    check("t3_ShotY", int'(ShotY), 432);
    repeat (9) do_tick(8'h00);

    // Held key fires once; re-press after cooldown fires; press during cooldown ignored
    auto_ack = 1'b1;
    r0 = req_rises;
    repeat (20) do_tick(8'h2C);
    check("t4_one_req_held", req_rises - r0, 1);
    do_tick(8'h00);
    repeat (8) do_tick(8'h00);
    do_tick(8'h2C);
    check("t4_second_req", req_rises - r0, 2);
    repeat (3) do_tick(8'h00);
    do_tick(8'h2C);
    check("t4_cooldown_ignore", req_rises - r0, 2);
    repeat (6) do_tick(8'h00);
    auto_ack = 1'b0;

    // Reset while REQ is pending with right held
    press_and_wait(lat);
    check("t5_req_seen", int'(FireReq), 1);
    keycode = 8'h07;
    repeat (4) cyc();
    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
    check("t5_rst_FireReq", int'(FireReq), 0);
    check("t5_rst_PlayerX", int'(PlayerX), 320);
    r0 = req_rises;
    repeat (5) do_tick(8'h2C);
    check("t5_no_fire_held", req_rises - r0, 0);
    check("t5_FireReq", int'(FireReq), 0);

    // Random-phase vsync: exactly one step per rising edge
    repeat (40) do_tick(8'h07);
    check("t6_tick_count", int'(PlayerX), 400);

    // Random keys and acks
    rand_ack = 1'b1;
    for (int n = 0; n < 200; n++) begin
      keys[4] = 8'($urandom);
      do_tick(keys[$urandom_range(0, 4)]);
    end
    rand_ack = 1'b0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
